mvm_out_fifo: RTL and testbench

MVM_OUT_FIFO -- requirements
Module: mvm_out_fifo

---
 rtl/mvm_out_fifo.sv | 150 +++++++++++++++
 tb/tb_mvm_out_fifo.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_out_fifo.sv
// mvm_out_fifo: beat FIFO between the MVM TX stream and the network, with a registered AXI-Stream output.
// Define MVM_OUT_FIFO_PKT_MODE_EN for store-and-forward packet mode; the default build is cut-through.
module mvm_out_fifo #(
    parameter int DATAW = 128,
    parameter int BYTEW = 8,
    parameter int IDW   = 32,
    parameter int DESTW = 12,
    parameter int USERW = 75,
    parameter int FIFOD = 64
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       axis_rx_tvalid,
    output logic                       axis_rx_tready,
    input  logic [DATAW-1:0]           axis_rx_tdata,
    input  logic [BYTEW-1:0]           axis_rx_tstrb,
    input  logic [BYTEW-1:0]           axis_rx_tkeep,
    input  logic [IDW-1:0]             axis_rx_tid,
    input  logic [DESTW-1:0]           axis_rx_tdest,
    input  logic [USERW-1:0]           axis_rx_tuser,
    input  logic                       axis_rx_tlast,

    output logic                       axis_tx_tvalid,
    input  logic                       axis_tx_tready,
    output logic [DATAW-1:0]           axis_tx_tdata,
    output logic [BYTEW-1:0]           axis_tx_tstrb,
    output logic [BYTEW-1:0]           axis_tx_tkeep,
    output logic [IDW-1:0]             axis_tx_tid,
    output logic [DESTW-1:0]           axis_tx_tdest,
    output logic [USERW-1:0]           axis_tx_tuser,
    output logic                       axis_tx_tlast,

    output logic [$clog2(FIFOD):0]     fifo_level,
    output logic                       pkt_overrun
);
    localparam int AW    = $clog2(FIFOD);
    localparam int LW    = AW + 1;
    localparam int BEATW = DATAW + 2*BYTEW + IDW + DESTW + USERW + 1;

    logic [BEATW-1:0] mem [FIFOD];
    logic [BEATW-1:0] rx_beat;
    logic [BEATW-1:0] head_beat;
    logic [BEATW-1:0] tx_q;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    arr_cnt;
    logic [LW-1:0]    occ;
    logic [LW-1:0]    occ_next;
    logic [LW-1:0]    level_q;
    logic             rx_ready_q;
    logic             tx_valid_q;
    logic             acc;
    logic             snd;
    logic             load;
    logic             release_ok;
    logic             head_last;

    // tlast sits in bit 0 of a stored beat
    assign rx_beat   = {axis_rx_tdata, axis_rx_tstrb, axis_rx_tkeep, axis_rx_tid,
                        axis_rx_tdest, axis_rx_tuser, axis_rx_tlast};
    assign head_beat = mem[rd_ptr];
    assign head_last = head_beat[0];

    assign occ      = arr_cnt + LW'(tx_valid_q);
    assign acc      = axis_rx_tvalid && rx_ready_q;
    assign snd      = tx_valid_q && axis_tx_tready;
    assign load     = (arr_cnt != '0) && release_ok && (!tx_valid_q || axis_tx_tready);
    assign occ_next = occ + LW'(acc) - LW'(snd);

    always_ff @(posedge clk) begin
        if (acc) begin
            mem[wr_ptr] <= rx_beat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            arr_cnt    <= '0;
            level_q    <= '0;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_q       <= '0;
        end else begin
            if (acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            arr_cnt    <= arr_cnt + LW'(acc) - LW'(load);
            level_q    <= occ_next;
            rx_ready_q <= (occ_next < LW'(FIFOD));
            if (load) begin
                tx_q       <= head_beat;
                tx_valid_q <= 1'b1;
            end else if (snd) begin
                tx_valid_q <= 1'b0;
            end
        end
    end

`ifdef MVM_OUT_FIFO_PKT_MODE_EN
    logic [LW-1:0] pkt_cnt;     // complete packets whose tlast is still in the array
    logic          in_pkt;
    logic          force_q;
    logic          overrun_q;
    logic          stuck;

    // Full with no complete packet anywhere: nothing could ever leave without a forced release.
    assign stuck      = (occ == LW'(FIFOD)) && (pkt_cnt == '0) && !(tx_valid_q && tx_q[0]);
    assign release_ok = in_pkt || (pkt_cnt != '0) || force_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt   <= '0;
            in_pkt    <= 1'b0;
            force_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pkt_cnt <= pkt_cnt + LW'(acc && axis_rx_tlast) - LW'(load && head_last);
            if (load) begin
                in_pkt <= !head_last;
            end
            if (load && head_last) begin
                force_q <= 1'b0;
            end else if (stuck) begin
                force_q <= 1'b1;
            end
            if (stuck) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign pkt_overrun = overrun_q;
`else
    assign release_ok  = 1'b1;
    assign pkt_overrun = 1'b0;
`endif

    assign {axis_tx_tdata, axis_tx_tstrb, axis_tx_tkeep, axis_tx_tid,
            axis_tx_tdest, axis_tx_tuser, axis_tx_tlast} = tx_q;
    assign axis_tx_tvalid = tx_valid_q;
    assign axis_rx_tready = rx_ready_q;
    assign fifo_level     = level_q;

endmodule

// File: tb/tb_mvm_out_fifo.sv
// tb_mvm_out_fifo: random and directed stimulus against a queue-based reference model of mvm_out_fifo.
// Packet-mode scenarios are built when MVM_OUT_FIFO_PKT_MODE_EN is defined.
module tb_mvm_out_fifo;
    localparam int DATAW = 128;
    localparam int BYTEW = 8;
    localparam int IDW   = 32;
    localparam int DESTW = 12;
    localparam int USERW = 75;
    localparam int FIFOD = 64;
    localparam int LW    = $clog2(FIFOD) + 1;
    localparam int BEATW = DATAW + 2*BYTEW + IDW + DESTW + USERW + 1;
    typedef logic [BEATW-1:0] beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              axis_rx_tvalid = 1'b0;
    logic              axis_rx_tready;
    logic [DATAW-1:0]  axis_rx_tdata = '0;
    logic [BYTEW-1:0]  axis_rx_tstrb = '0;
    logic [BYTEW-1:0]  axis_rx_tkeep = '0;
    logic [IDW-1:0]    axis_rx_tid = '0;
    logic [DESTW-1:0]  axis_rx_tdest = '0;
    logic [USERW-1:0]  axis_rx_tuser = '0;
    logic              axis_rx_tlast = 1'b0;
    logic              axis_tx_tvalid;
    logic              axis_tx_tready = 1'b0;
    logic [DATAW-1:0]  axis_tx_tdata;
    logic [BYTEW-1:0]  axis_tx_tstrb;
    logic [BYTEW-1:0]  axis_tx_tkeep;
    logic [IDW-1:0]    axis_tx_tid;
    logic [DESTW-1:0]  axis_tx_tdest;
    logic [USERW-1:0]  axis_tx_tuser;
    logic              axis_tx_tlast;
    logic [LW-1:0]     fifo_level;
    logic              pkt_overrun;

    always #5 clk = ~clk;

    mvm_out_fifo #(.DATAW(DATAW), .BYTEW(BYTEW), .IDW(IDW), .DESTW(DESTW),
                   .USERW(USERW), .FIFOD(FIFOD)) dut (
        .clk(clk), .rst(rst),
        .axis_rx_tvalid(axis_rx_tvalid), .axis_rx_tready(axis_rx_tready),
        .axis_rx_tdata(axis_rx_tdata), .axis_rx_tstrb(axis_rx_tstrb),
        .axis_rx_tkeep(axis_rx_tkeep), .axis_rx_tid(axis_rx_tid),
        .axis_rx_tdest(axis_rx_tdest), .axis_rx_tuser(axis_rx_tuser),
        .axis_rx_tlast(axis_rx_tlast),
        .axis_tx_tvalid(axis_tx_tvalid), .axis_tx_tready(axis_tx_tready),
        .axis_tx_tdata(axis_tx_tdata), .axis_tx_tstrb(axis_tx_tstrb),
        .axis_tx_tkeep(axis_tx_tkeep), .axis_tx_tid(axis_tx_tid),
        .axis_tx_tdest(axis_tx_tdest), .axis_tx_tuser(axis_tx_tuser),
        .axis_tx_tlast(axis_tx_tlast),
        .fifo_level(fifo_level), .pkt_overrun(pkt_overrun)
    );

    beat_t q[$];           // beats accepted and not yet sent, oldest first
    int    n_checks = 0;
    int    n_errors = 0;
    int    n_acc = 0;
    int    n_sent = 0;
    bit    ct_check = 1'b0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic beat_t rx_beat();
        return {axis_rx_tdata, axis_rx_tstrb, axis_rx_tkeep, axis_rx_tid,
                axis_rx_tdest, axis_rx_tuser, axis_rx_tlast};
    endfunction

    function automatic beat_t tx_beat();
        return {axis_tx_tdata, axis_tx_tstrb, axis_tx_tkeep, axis_tx_tid,
                axis_tx_tdest, axis_tx_tuser, axis_tx_tlast};
    endfunction

    function automatic logic [DATAW-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive_beat(input logic [DATAW-1:0] data, input logic last);
        logic [95:0] u;
        u = {$urandom(), $urandom(), $urandom()};
        axis_rx_tdata = data;
        axis_rx_tstrb = BYTEW'($urandom());
        axis_rx_tkeep = BYTEW'($urandom());
        axis_rx_tid   = IDW'($urandom());
        axis_rx_tdest = DESTW'($urandom());
        axis_rx_tuser = u[USERW-1:0];
        axis_rx_tlast = last;
    endtask

    // One clock: log handshakes seen before the edge into the model, then check state after it.
    task automatic step();
        bit a;
        bit s;
        a = axis_rx_tvalid && axis_rx_tready;
        s = axis_tx_tvalid && axis_tx_tready;
        if (axis_tx_tvalid) begin
            check_eq("tx_has_data", q.size() != 0, 1);
            if (q.size() != 0) check_eq("tx_beat", tx_beat(), q[0]);
        end
        if (s && q.size() != 0) begin
            void'(q.pop_front());
            n_sent++;
        end
        if (a) begin
            q.push_back(rx_beat());
            n_acc++;
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("fifo_level", fifo_level, q.size());
        check_eq("rx_tready", axis_rx_tready, q.size() < FIFOD);
        if (ct_check) check_eq("tx_tvalid_ct", axis_tx_tvalid, (int'(q.size()) - int'(a)) > 0);
    endtask

    task automatic drain(input int max_cycles);
        axis_tx_tready = 1'b1;
        for (int i = 0; i < max_cycles && q.size() != 0; i++) step();
        check_eq("drain_empty", q.size(), 0);
    endtask

    int  base;
    int  cyc;
    int  peak;
    bit  pending;
    bit  got_valid;

    initial begin
`ifdef MVM_OUT_FIFO_PKT_MODE_EN
        ct_check = 1'b0;
`else
        ct_check = 1'b1;
`endif
        // reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_tx_tvalid", axis_tx_tvalid, 0);
        check_eq("rst_rx_tready", axis_rx_tready, 0);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_overrun", pkt_overrun, 0);
        check_eq("rst_tx_beat", tx_beat(), 0);
        rst = 1'b0;
        #1;
        check_eq("rx_tready_before_edge", axis_rx_tready, 0);
        @(negedge clk);
        step();

`ifndef MVM_OUT_FIFO_PKT_MODE_EN
        // cut-through smoke: 10 indexed beats, always-ready sink
        base = n_sent;
        axis_tx_tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_beat(DATAW'(i), i == 9);
            axis_rx_tvalid = 1'b1;
            step();
        end
        axis_rx_tvalid = 1'b0;
        drain(20);
        check_eq("smoke_sent", n_sent - base, 10);
`endif

        // fill against a stalled sink, then release
        axis_tx_tready = 1'b0;
        base = n_acc;
        for (int i = 0; i < 70; i++) begin
            drive_beat(DATAW'(i), i == 63);
            axis_rx_tvalid = 1'b1;
            step();
        end
        axis_rx_tvalid = 1'b0;
        check_eq("fill_accepted", n_acc - base, 64);
        check_eq("fill_rx_tready", axis_rx_tready, 0);
        check_eq("fill_level", fifo_level, 64);
        base = n_sent;
        drain(200);
        check_eq("fill_sent", n_sent - base, 64);
        check_eq("fill_rx_tready_after", axis_rx_tready, 1);

        // random valid/ready with wrap and simultaneous push/pop
        base = n_acc;
        pending = 1'b0;
        cyc = 0;
        while (n_acc - base < 200 && cyc < 5000) begin
            if (!pending && $urandom_range(1) == 1) begin
                drive_beat(rand_data(), (n_acc - base == 199) || ($urandom_range(7) == 0));
                axis_rx_tvalid = 1'b1;
                pending = 1'b1;
            end
            axis_tx_tready = ($urandom_range(1) == 1);
            peak = n_acc;
            step();
            if (n_acc != peak) begin
                pending = 1'b0;
                axis_rx_tvalid = 1'b0;
            end
            cyc++;
        end
        axis_rx_tvalid = 1'b0;
        check_eq("rand_accepted", n_acc - base, 200);
        drain(500);

        // reset in the middle of a stream
        axis_tx_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_beat(rand_data(), i == 19);
            axis_rx_tvalid = 1'b1;
            step();
        end
        axis_rx_tvalid = 1'b0;
        step();
        check_eq("mid_level", fifo_level, 20);
        check_eq("mid_tx_tvalid", axis_tx_tvalid, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_tx_tvalid", axis_tx_tvalid, 0);
        check_eq("async_level", fifo_level, 0);
        check_eq("async_rx_tready", axis_rx_tready, 0);
        check_eq("async_tx_beat", tx_beat(), 0);
        check_eq("async_overrun", pkt_overrun, 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        step();
        base = n_sent;
        axis_tx_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_beat(rand_data(), i == 2);
            axis_rx_tvalid = 1'b1;
            step();
        end
        axis_rx_tvalid = 1'b0;
        drain(20);
        check_eq("post_rst_sent", n_sent - base, 3);

`ifdef MVM_OUT_FIFO_PKT_MODE_EN
        // 5-beat packet is held until its tlast is in, then leaves back to back
        axis_tx_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_beat(DATAW'(i), i == 4);
            axis_rx_tvalid = 1'b1;
            step();
            check_eq("pkt_hold", axis_tx_tvalid, 0);
        end
        axis_rx_tvalid = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            check_eq("pkt_contig", axis_tx_tvalid, 1);
            step();
        end
        check_eq("pkt_done_valid", axis_tx_tvalid, 0);
        check_eq("pkt_done_empty", q.size(), 0);
        check_eq("pkt_no_overrun", pkt_overrun, 0);

        // oversized packet forces a cut-through release
        base = n_acc;
        n_sent = 0;
        pending = 1'b0;
        got_valid = 1'b0;
        peak = 0;
        cyc = 0;
        while (n_acc - base < 70 && cyc < 2000) begin
            if (!pending) begin
                drive_beat(DATAW'(n_acc - base), (n_acc - base) == 69);
                axis_rx_tvalid = 1'b1;
                pending = 1'b1;
            end
            if (!got_valid && q.size() > peak) peak = q.size();
            base = base;
            begin
                int before;
                before = n_acc;
                step();
                if (n_acc != before) begin
                    pending = 1'b0;
                    axis_rx_tvalid = 1'b0;
                end
            end
            if (!got_valid && axis_tx_tvalid) begin
                got_valid = 1'b1;
                check_eq("pkt_force_peak", peak, 64);
                check_eq("pkt_overrun_set", pkt_overrun, 1);
            end
            cyc++;
        end
        axis_rx_tvalid = 1'b0;
        check_eq("big_accepted", n_acc - base, 70);
        drain(300);
        check_eq("big_sent", n_sent, 70);
        check_eq("big_overrun_sticky", pkt_overrun, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
